// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch/decode front end: opcodes, instruction
// field layout, decoded-field payload, FSM state encoding.
package cpu_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned DATA_W  = 20;
  localparam int unsigned OPC_W   = 5;
  localparam int unsigned SEL_W   = 4;
  localparam int unsigned IMM_W   = 15;

  // Instruction layout: [31:27] opcode, [26:23] dst, [22:19] src1,
  // [18:15] src2, [14:0] immediate.
  localparam int unsigned OPC_LSB  = 27;
  localparam int unsigned DST_LSB  = 23;
  localparam int unsigned SRC1_LSB = 19;
  localparam int unsigned SRC2_LSB = 15;
  localparam int unsigned IMM_LSB  = 0;

  localparam logic [OPC_W-1:0] OP_ADD  = 5'b00000;
  localparam logic [OPC_W-1:0] OP_SUB  = 5'b00010;
  localparam logic [OPC_W-1:0] OP_HALT = 5'b11111;

  // opcode[4]: src1 operand comes from the immediate.
  // opcode[3]: src2 operand comes from the immediate.
  localparam int unsigned OPC_SRC1_IMM_BIT = 4;
  localparam int unsigned OPC_SRC2_IMM_BIT = 3;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    ISSUE = 2'd2,
    HALT  = 2'd3
  } fd_state_t;

  // Decoded instruction fields as held for the ALU stage.
  typedef struct packed {
    logic [OPC_W-1:0]  opcode;
    logic [SEL_W-1:0]  dst_sel;
    logic [SEL_W-1:0]  src1_sel;
    logic [SEL_W-1:0]  src2_sel;
    logic [DATA_W-1:0] imm;
  } fd_fields_t;

  // Sign-extend the 15-bit instruction immediate to the datapath width.
  function automatic logic [DATA_W-1:0] sext_imm(input logic [IMM_W-1:0] imm);
    return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

  function automatic logic src1_is_imm(input logic [OPC_W-1:0] opc);
    return opc[OPC_SRC1_IMM_BIT];
  endfunction

  function automatic logic src2_is_imm(input logic [OPC_W-1:0] opc);
    return opc[OPC_SRC2_IMM_BIT];
  endfunction

endpackage

// File: rtl/instr_field_split.sv
// Pure combinational slicing of a 32-bit instruction word into its fields.
module instr_field_split
  import cpu_pkg::*;
(
  input  logic [31:0] instr,
  output logic [4:0]  opcode,
  output logic [3:0]  dst_sel,
  output logic [3:0]  src1_sel,
  output logic [3:0]  src2_sel,
  output logic [19:0] imm
);

  // Field extraction and immediate sign extension.
  always_comb begin
    opcode   = instr[OPC_LSB  +: OPC_W];
    dst_sel  = instr[DST_LSB  +: SEL_W];
    src1_sel = instr[SRC1_LSB +: SEL_W];
    src2_sel = instr[SRC2_LSB +: SEL_W];
    imm      = sext_imm(instr[IMM_LSB +: IMM_W]);
  end

endmodule

// File: rtl/fetch_decode.sv
// Instruction fetch and decode stage feeding the ALU. Three-cycle
// FETCH/WAIT/ISSUE sequence per instruction, branch redirect, terminal HALT.
module fetch_decode
  import cpu_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 20,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_rd,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_data,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              enable,
  output logic [4:0]        opcode,
  output logic [3:0]        dst_sel,
  output logic [3:0]        src1_sel,
  output logic [3:0]        src2_sel,
  output logic [19:0]       src1_imm,
  output logic [19:0]       src2_imm,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic [CNT_W-1:0]  instr_count
);

  fd_state_t  state;
  fd_state_t  next_state;
  fd_fields_t fields_q;

  logic [4:0]  w_opcode;
  logic [3:0]  w_dst_sel;
  logic [3:0]  w_src1_sel;
  logic [3:0]  w_src2_sel;
  logic [19:0] w_imm;

  instr_field_split u_split (
    .instr    (imem_data),
    .opcode   (w_opcode),
    .dst_sel  (w_dst_sel),
    .src1_sel (w_src1_sel),
    .src2_sel (w_src2_sel),
    .imm      (w_imm)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: branch beats stall, HALT is absorbing.
  always_comb begin
    next_state = state;
    case (state)
      FETCH: begin
        next_state = branch_taken ? FETCH : WAIT;
      end
      WAIT: begin
        if (branch_taken) begin
          next_state = FETCH;
        end else if (w_opcode == OP_HALT) begin
          next_state = HALT;
        end else begin
          next_state = ISSUE;
        end
      end
      ISSUE: begin
        if (branch_taken) begin
          next_state = FETCH;
        end else if (stall) begin
          next_state = ISSUE;
        end else begin
          next_state = FETCH;
        end
      end
      HALT: begin
        next_state = HALT;
      end
      default: begin
        next_state = FETCH;
      end
    endcase
  end

  // State-decoded strobes; both are forced low while reset is asserted.
  always_comb begin
    imem_rd = 1'b0;
    enable  = 1'b0;
    if (!rst) begin
      case (state)
        FETCH:   imem_rd = 1'b1;
        ISSUE:   enable  = ~stall & ~branch_taken;
        default: begin
          imem_rd = 1'b0;
          enable  = 1'b0;
        end
      endcase
    end
  end

  // PC, decoded-field register, retired counter and halt flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      fields_q    <= '0;
      instr_count <= '0;
      halted      <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (branch_taken) begin
            pc <= branch_target;
          end
        end
        WAIT: begin
          // A redirect discards the word being returned by the ROM.
          if (branch_taken) begin
            pc <= branch_target;
          end else begin
            fields_q.opcode   <= w_opcode;
            fields_q.dst_sel  <= w_dst_sel;
            fields_q.src1_sel <= w_src1_sel;
            fields_q.src2_sel <= w_src2_sel;
            fields_q.imm      <= w_imm;
          end
        end
        ISSUE: begin
          if (branch_taken) begin
            pc <= branch_target;
          end else if (!stall) begin
            pc <= pc + ADDR_W'(1);
            if (instr_count != {CNT_W{1'b1}}) begin
              instr_count <= instr_count + CNT_W'(1);
            end
          end
        end
        default: begin
          pc <= pc;
        end
      endcase
      halted <= (next_state == HALT);
    end
  end

  assign imem_addr = pc;
  assign opcode    = fields_q.opcode;
  assign dst_sel   = fields_q.dst_sel;
  assign src1_sel  = fields_q.src1_sel;
  assign src2_sel  = fields_q.src2_sel;
  assign src1_imm  = fields_q.imm;
  assign src2_imm  = fields_q.imm;

endmodule

// File: tb/tb_fetch_decode.sv
// Directed bench for fetch_decode: reset, decode, immediates, stall,
// branch squash, HALT, branch-over-HALT and PC wrap.
module tb_fetch_decode;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [19:0] branch_target;
  logic        imem_rd;
  logic [19:0] imem_addr;
  logic [31:0] imem_data;
  logic        enable;
  logic [4:0]  opcode;
  logic [3:0]  dst_sel, src1_sel, src2_sel;
  logic [19:0] src1_imm, src2_imm;
  logic [19:0] pc;
  logic        halted;
  logic [15:0] instr_count;

  logic        rst2;
  logic        imem_rd2;
  logic [19:0] imem_addr2;
  logic [31:0] imem_data2;
  logic        enable2;
  logic [4:0]  opcode2;
  logic [3:0]  dst_sel2, src1_sel2, src2_sel2;
  logic [19:0] src1_imm2, src2_imm2;
  logic [19:0] pc2;
  logic        halted2;
  logic [15:0] instr_count2;
  logic        zero_bit = 1'b0;
  logic [19:0] zero_addr = 20'h0;

  logic [31:0] rom [0:255];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fetch_decode #(.ADDR_W(20), .RESET_PC(20'h00000), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .imem_rd(imem_rd), .imem_addr(imem_addr),
    .imem_data(imem_data), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .enable(enable), .opcode(opcode),
    .dst_sel(dst_sel), .src1_sel(src1_sel), .src2_sel(src2_sel),
    .src1_imm(src1_imm), .src2_imm(src2_imm), .pc(pc), .halted(halted),
    .instr_count(instr_count)
  );

  fetch_decode #(.ADDR_W(20), .RESET_PC(20'hFFFFF), .CNT_W(16)) dut_w (
    .clk(clk), .rst(rst2), .imem_rd(imem_rd2), .imem_addr(imem_addr2),
    .imem_data(imem_data2), .stall(zero_bit), .branch_taken(zero_bit),
    .branch_target(zero_addr), .enable(enable2), .opcode(opcode2),
    .dst_sel(dst_sel2), .src1_sel(src1_sel2), .src2_sel(src2_sel2),
    .src1_imm(src1_imm2), .src2_imm(src2_imm2), .pc(pc2), .halted(halted2),
    .instr_count(instr_count2)
  );

  // Synchronous ROM models, one per instance.
  always @(posedge clk) begin
    if (imem_rd)  imem_data  <= rom[imem_addr[7:0]];
    if (imem_rd2) imem_data2 <= rom[imem_addr2[7:0]];
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    #1;
    total++; if (imem_rd !== 1'b0) begin bad++; $display("FAIL reset_rd got=%0h exp=0", imem_rd); end
    total++; if (enable !== 1'b0) begin bad++; $display("FAIL reset_en got=%0h exp=0", enable); end
    total++; if (pc !== 20'h0) begin bad++; $display("FAIL reset_pc got=%0h exp=0", pc); end
    total++; if (instr_count !== 16'h0) begin bad++; $display("FAIL reset_cnt got=%0h exp=0", instr_count); end
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL reset_halted got=%0h exp=0", halted); end
    total++; if ({opcode, dst_sel, src1_sel, src2_sel, src1_imm} !== 37'h0) begin bad++; $display("FAIL reset_fields got=%0h exp=0", {opcode, dst_sel, src1_sel, src2_sel, src1_imm}); end
  endtask

  task automatic test_basic;
    rst = 1'b0;
    #1;
    total++; if (imem_rd !== 1'b1) begin bad++; $display("FAIL basic_rd0 got=%0h exp=1", imem_rd); end
    total++; if (imem_addr !== 20'h0) begin bad++; $display("FAIL basic_addr0 got=%0h exp=0", imem_addr); end
    tick();
    total++; if ({imem_rd, enable} !== 2'b00) begin bad++; $display("FAIL basic_wait got=%0b exp=00", {imem_rd, enable}); end
    tick();
    total++; if (enable !== 1'b1) begin bad++; $display("FAIL basic_en got=%0h exp=1", enable); end
    total++; if ({opcode, dst_sel, src1_sel, src2_sel} !== {5'd0, 4'd2, 4'd3, 4'd0}) begin bad++; $display("FAIL basic_fields got=%0h exp=%0h", {opcode, dst_sel, src1_sel, src2_sel}, {5'd0, 4'd2, 4'd3, 4'd0}); end
    tick();
    total++; if (pc !== 20'h1) begin bad++; $display("FAIL basic_pc got=%0h exp=1", pc); end
    total++; if (instr_count !== 16'h1) begin bad++; $display("FAIL basic_cnt got=%0h exp=1", instr_count); end
    total++; if ({imem_rd, imem_addr} !== {1'b1, 20'h1}) begin bad++; $display("FAIL basic_refetch got=%0h exp=%0h", {imem_rd, imem_addr}, {1'b1, 20'h1}); end
  endtask

  task automatic test_imm;
    tick();
    tick();
    total++; if (enable !== 1'b1) begin bad++; $display("FAIL imm_en got=%0h exp=1", enable); end
    total++; if (opcode !== 5'b01000) begin bad++; $display("FAIL imm_opc got=%0h exp=8", opcode); end
    total++; if (src2_imm !== 20'hFFFFF) begin bad++; $display("FAIL imm_neg_src2 got=%0h exp=fffff", src2_imm); end
    total++; if (src1_imm !== 20'hFFFFF) begin bad++; $display("FAIL imm_neg_src1 got=%0h exp=fffff", src1_imm); end
    tick();
    tick();
    tick();
    total++; if (src2_imm !== 20'h00005) begin bad++; $display("FAIL imm_pos_src2 got=%0h exp=5", src2_imm); end
    total++; if (src1_imm !== 20'h00005) begin bad++; $display("FAIL imm_pos_src1 got=%0h exp=5", src1_imm); end
    tick();
    total++; if ({pc, instr_count} !== {20'h3, 16'h3}) begin bad++; $display("FAIL imm_pc_cnt got=%0h exp=%0h", {pc, instr_count}, {20'h3, 16'h3}); end
  endtask

  task automatic test_stall;
    tick();
    tick();
    stall = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      total++; if (enable !== 1'b0) begin bad++; $display("FAIL stall_en%0d got=%0h exp=0", i, enable); end
      total++; if ({opcode, dst_sel, src1_sel, src2_sel, pc} !== {5'd2, 4'd7, 4'd1, 4'd9, 20'h3}) begin bad++; $display("FAIL stall_hold%0d got=%0h exp=%0h", i, {opcode, dst_sel, src1_sel, src2_sel, pc}, {5'd2, 4'd7, 4'd1, 4'd9, 20'h3}); end
    end
    tick();
    stall = 1'b0;
    #1;
    total++; if (enable !== 1'b1) begin bad++; $display("FAIL stall_release got=%0h exp=1", enable); end
    tick();
    total++; if ({pc, instr_count} !== {20'h4, 16'h4}) begin bad++; $display("FAIL stall_pc_cnt got=%0h exp=%0h", {pc, instr_count}, {20'h4, 16'h4}); end
  endtask

  task automatic test_branch;
    tick();
    tick();
    branch_taken  = 1'b1;
    branch_target = 20'h00040;
    #1;
    total++; if (enable !== 1'b0) begin bad++; $display("FAIL branch_squash got=%0h exp=0", enable); end
    tick();
    branch_taken = 1'b0;
    #1;
    total++; if (instr_count !== 16'h4) begin bad++; $display("FAIL branch_cnt got=%0h exp=4", instr_count); end
    total++; if ({imem_rd, imem_addr} !== {1'b1, 20'h00040}) begin bad++; $display("FAIL branch_fetch got=%0h exp=%0h", {imem_rd, imem_addr}, {1'b1, 20'h00040}); end
    total++; if (dst_sel !== 4'd5) begin bad++; $display("FAIL branch_fields got=%0h exp=5", dst_sel); end
  endtask

  task automatic test_halt;
    rom[0] = 32'h01180000;
    rom[1] = 32'hF8000000;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) tick();
    total++; if (halted !== 1'b1) begin bad++; $display("FAIL halt_flag got=%0h exp=1", halted); end
    total++; if ({imem_rd, enable} !== 2'b00) begin bad++; $display("FAIL halt_strobes got=%0b exp=00", {imem_rd, enable}); end
    total++; if ({opcode, pc, instr_count} !== {5'h1F, 20'h1, 16'h1}) begin bad++; $display("FAIL halt_state got=%0h exp=%0h", {opcode, pc, instr_count}, {5'h1F, 20'h1, 16'h1}); end
    branch_taken  = 1'b1;
    branch_target = 20'h00010;
    #1;
    total++; if ({imem_rd, enable} !== 2'b00) begin bad++; $display("FAIL halt_br_strobes got=%0b exp=00", {imem_rd, enable}); end
    tick();
    tick();
    total++; if ({halted, imem_rd, pc} !== {1'b1, 1'b0, 20'h1}) begin bad++; $display("FAIL halt_br_ignored got=%0h exp=%0h", {halted, imem_rd, pc}, {1'b1, 1'b0, 20'h1}); end
    branch_taken = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    total++; if ({halted, pc, imem_rd} !== {1'b0, 20'h0, 1'b1}) begin bad++; $display("FAIL halt_exit got=%0h exp=%0h", {halted, pc, imem_rd}, {1'b0, 20'h0, 1'b1}); end
  endtask

  task automatic test_branch_beats_halt;
    rom[0] = 32'hF8000000;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    tick();
    branch_taken  = 1'b1;
    branch_target = 20'h00005;
    #1;
    tick();
    branch_taken = 1'b0;
    #1;
    total++; if ({halted, imem_rd, imem_addr} !== {1'b0, 1'b1, 20'h00005}) begin bad++; $display("FAIL brhalt got=%0h exp=%0h", {halted, imem_rd, imem_addr}, {1'b0, 1'b1, 20'h00005}); end
    tick();
    tick();
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL brhalt_later got=%0h exp=0", halted); end
  endtask

  task automatic test_wrap;
    rst2 = 1'b0;
    #1;
    total++; if ({imem_rd2, imem_addr2} !== {1'b1, 20'hFFFFF}) begin bad++; $display("FAIL wrap_fetch got=%0h exp=%0h", {imem_rd2, imem_addr2}, {1'b1, 20'hFFFFF}); end
    tick();
    tick();
    total++; if (enable2 !== 1'b1) begin bad++; $display("FAIL wrap_en got=%0h exp=1", enable2); end
    tick();
    total++; if ({pc2, instr_count2} !== {20'h0, 16'h1}) begin bad++; $display("FAIL wrap_pc got=%0h exp=%0h", {pc2, instr_count2}, {20'h0, 16'h1}); end
    total++; if ({imem_rd2, imem_addr2} !== {1'b1, 20'h0}) begin bad++; $display("FAIL wrap_refetch got=%0h exp=%0h", {imem_rd2, imem_addr2}, {1'b1, 20'h0}); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 32'h0;
    rom[0]    = 32'h01180000;
    rom[1]    = {5'b01000, 4'd0, 4'd0, 4'd1, 15'h7FFF};
    rom[2]    = {5'b01000, 4'd1, 4'd0, 4'd2, 15'h0005};
    rom[3]    = {5'd2, 4'd7, 4'd1, 4'd9, 15'h1234};
    rom[4]    = {5'd0, 4'd5, 4'd6, 4'd7, 15'h0000};
    rom[5]    = 32'h01180000;
    rom[8'h40] = 32'h01180000;
    rom[8'hFF] = 32'h0;
    rst           = 1'b1;
    rst2          = 1'b1;
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 20'h0;

    test_reset();
    test_basic();
    test_imm();
    test_stall();
    test_branch();
    test_halt();
    test_branch_beats_halt();
    rom[0] = 32'h0;
    test_wrap();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_decode.md
Name: fetch_decode

Overview:
- Upstream neighbour of the ALU stage.
- Fetches 32-bit instruction words from a synchronous instruction ROM and slices them into opcode, register selects and sign-extended immediates.
- Presents those fields with a one-cycle enable pulse to the ALU stage, which consumes them directly.
- Owns the program counter: sequential increment, redirect on taken branch (target from the ALU's PC path), terminal HALT state.

Parameters:
- ADDR_W, 20, width of PC / instruction-memory address; PC wraps modulo 2^ADDR_W.
- RESET_PC, 0, PC value loaded on reset.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- imem_rd  out  1  ROM read strobe.
- imem_addr  out  ADDR_W  ROM address (= pc).
- imem_data  in  32  ROM data, valid the cycle after imem_rd.
- stall  in  1  downstream not ready; holds the issued instruction.
- branch_taken  in  1  redirect request.
- branch_target  in  ADDR_W  redirect address.
- enable  out  1  one-cycle issue strobe to the ALU.
- opcode  out  5  instr[31:27].
- dst_sel  out  4  instr[26:23].
- src1_sel  out  4  instr[22:19].
- src2_sel  out  4  instr[18:15].
- src1_imm  out  20  sign-extended instr[14:0].
- src2_imm  out  20  sign-extended instr[14:0] (same value as src1_imm).
- pc  out  ADDR_W  address of the current instruction.
- halted  out  1  HALT reached.
- instr_count  out  CNT_W  issued-instruction count.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=FETCH, pc=RESET_PC.
  - All decoded field outputs=0; halted=0; instr_count=0.
  - imem_rd=0 and enable=0 while rst is high.
- FSM states: FETCH, WAIT, ISSUE, HALT.
- FETCH: imem_rd=1, imem_addr=pc; next state WAIT.
- WAIT: imem_data is valid.
  - Fields are registered at the end of this cycle.
  - If instr[31:27]==OP_HALT (5'b11111): go to HALT; fields are still loaded but no issue occurs.
  - Otherwise go to ISSUE.
- ISSUE: enable = ~stall & ~branch_taken (combinational from state).
  - Fields stay stable for every cycle spent in ISSUE.
  - When enable=1: pc <= pc+1 (wraps to 0 from 2^ADDR_W-1), instr_count += 1 (saturates at all-ones), next state FETCH.
  - When stall=1: remain in ISSUE and hold everything.
- Throughput: 3 cycles per instruction with no stalls. The first enable occurs in the 3rd cycle after rst deasserts.
- Branch handling (branch_taken=1 in FETCH, WAIT or ISSUE):
  - pc <= branch_target and next state FETCH.
  - Any in-flight fetch is discarded.
  - An instruction in ISSUE is squashed: enable=0, it is not counted, and the fields hold until the next WAIT.
  - Branch has priority over stall and over the pc+1 increment.
  - Branch arriving in the same WAIT cycle as a HALT word: branch wins and HALT is not entered.
- HALT: halted=1, imem_rd=0, enable=0. Branch is ignored; only rst exits.
- Priority order: rst > branch_taken > stall > normal sequencing.
- No combinational path from imem_data to any output; enable is the only combinational output.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode constants: OP_ADD=5'b00000, OP_SUB=5'b00010, OP_HALT=5'b11111.
  - Meaning of opcode[4] (src1 takes immediate) and opcode[3] (src2 takes immediate).
  - Instruction field bit positions and widths.
  - The fd_state_t enum.
  - DATA_W=20.
- One combinational sub-module, instr_field_split: 32-bit word in, all fields plus the 15-to-20-bit sign extension out. The FSM, PC and counter stay in fetch_decode.

Test Plan:
- Reset release, ROM[0]=0x01180000 (ADD, dst=2, src1=3, src2=0) -> imem_rd at cycle 0 with addr 0; cycle 2: enable=1, opcode=0, dst_sel=2, src1_sel=3, src2_sel=0; pc becomes 1; instr_count=1.
- Immediate word with opcode=5'b01000, instr[14:0]=0x7FFF -> src2_imm=0xFFFFF, and src1_imm is the same value. Repeat with 0x0005 -> 0x00005.
- stall high for 4 cycles on entry to ISSUE -> enable stays 0 for 4 cycles with fields stable; enable pulses on the 5th cycle; pc increments exactly once.
- branch_taken with target 0x00040 asserted in the same cycle as an unstalled ISSUE -> enable=0, instr_count unchanged; next FETCH has imem_addr=0x00040.
- ROM[1]=0xF8000000 (HALT) -> after the instruction at address 0 issues, halted=1 and no further imem_rd or enable. branch_taken is then ignored; rst clears halted and pc=0.
- RESET_PC=0xFFFFF, ROM word NOP (opcode 0) -> after issue pc=0x00000, and the next fetch reads address 0.
